fdiv_share_ctrl: RTL and testbench
==================================

// Module: fdiv_share_ctrl
// PURPOSE
//  Shares one combinational fdiv (single-precision, y = x1/x2) among NREQ requesters.
//  Arbitrates round-robin and registers the operands feeding fdiv.
//  Holds the operands stable for DIV_CYCLES cycles, because fdiv is constrained as a multicycle path.
//  Captures y and returns it to the winning requester over a valid/ready handshake.
//  Sits between the FPU issue ports and the shared fdiv datapath.
// PARAMETERS
//  NREQ        2   number of requesters (2..8)
//  DIV_CYCLES  4   cycles the operands are held before y is sampled (1..15)
//  TAG_W       5   width of the opaque tag returned with each result
// PORTS
//  clk        in   1           clock
//  rstn       in   1           async active-low reset
//  flush      in   1           sync abort; drops any in-flight op
//  req_valid  in   NREQ        request valid, one bit per requester
//  req_ready  out  NREQ        request accepted (one-hot or zero)
//  req_x1     in   NREQ*32     dividend of requester i at [32i+:32]
//  req_x2     in   NREQ*32     divisor of requester i at [32i+:32]
//  req_tag    in   NREQ*TAG_W  tag of requester i
//  resp_valid out  NREQ        result valid for requester i (one-hot or zero)
//  resp_ready in   NREQ        requester i consumes result
//  resp_y     out  32          quotient (shared bus, valid with resp_valid)
//  resp_tag   out  TAG_W       tag of the accepted request
//  busy       out  1           high whenever state != IDLE
// BEHAVIOUR
//  Reset (rstn low, async): state=IDLE, cnt=0, rr_ptr=0, op/result regs=0.
//   All outputs are 0 while rstn is low.
//  Reset asserted mid-operation discards the op; no response is ever produced for it.
//  FSM states: IDLE, EXEC, DONE.
//  IDLE:
//   - grant g = first i with req_valid[i], searching from rr_ptr upward modulo NREQ.
//   - req_ready[g]=1 combinationally; all other req_ready bits are 0; none if no valid.
//   - on accept: latch x1/x2/tag[g] and g, set cnt=DIV_CYCLES-1, go to EXEC.
//  EXEC:
//   - fdiv inputs come only from the op regs, never from req_* directly.
//   - cnt decrements each cycle.
//   - at cnt==0: capture fdiv y into the result reg and go to DONE.
//   - latency from accept edge to resp_valid high = DIV_CYCLES+1 cycles.
//  DONE:
//   - resp_valid[g]=1; resp_y and resp_tag stay stable until handshake.
//   - resp_ready on a non-granted index is ignored.
//   - on resp_ready[g]: rr_ptr=(g+1)%NREQ, go to IDLE.
//  Throughput: one bubble cycle in IDLE after each result (DIV_CYCLES+2 cycles per op).
//  req_ready is 0 in EXEC and DONE; requesters hold their request until accepted.
//  flush (any state): next state IDLE, resp_valid=0, rr_ptr unchanged.
//   - No accept occurs in a flush cycle.
//   - flush has priority over a same-cycle handshake.
//  Result is bit-exact with fdiv; there is no extra rounding or special-case logic.
//  Exponent/NaN handling is owned by fdiv: y within ±2 ulp of IEEE, underflow flushed to exp 0.
// STRUCTURE
//  Package fdiv_ctrl_pkg holds:
//   - typedef enum logic[1:0] {IDLE, EXEC, DONE} fdiv_state_t
//   - localparam FP_W=32
//   - function rr_pick(valid, ptr)
//  Sub-module rr_arbiter #(N): combinational round-robin pick, outputs one-hot grant and index.
//  Instantiates the existing fdiv(x1,x2,y) once.
// TESTING
//  1. Single op: req0 x1=0x40C00000, x2=0x40000000, tag=3 -> resp_valid[0] at accept+5,
//     y=0x40400000, tag=3.
//  2. Both requesters valid from reset -> grant order 0,1,0,1; each resp carries its own tag;
//     ops spaced 6 cycles apart.
//  3. 1.0/3.0 (0x3F800000/0x40400000) -> y within 2 ulp of 0x3EAAAAAB.
//     resp_y stable while resp_ready=0 for 10 cycles.
//  4. Underflow 0x00800000/0x7F000000 -> y[30:23]==0.
//     resp_ready[1] asserted while g=0 -> ignored, state stays DONE.
//  5. flush asserted in EXEC (cnt=2) -> no resp_valid; busy=0 next cycle; next accept still
//     follows rr_ptr.
//  6. rstn pulled low in DONE -> all outputs 0 immediately; after release, idle with rr_ptr=0.

Source files
------------

// File: rtl/fdiv_ctrl_pkg.sv
// Shared types and helpers for the fdiv sharing controller.
package fdiv_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } fdiv_state_t;

    localparam int unsigned FP_W   = 32;
    localparam int unsigned RR_MAX = 8;

    // Round-robin pick over up to RR_MAX requesters: returns {found, index}.
    // Search starts at ptr and wraps modulo n.
    function automatic logic [3:0] rr_pick(input logic [7:0] valid,
                                           input logic [2:0] ptr,
                                           input int unsigned n);
        logic [3:0]  pick;
        int unsigned idx;
        pick = '0;
        idx  = 0;
        for (int unsigned k = 0; k < RR_MAX; k++) begin
            if (k < n && !pick[3]) begin
                idx = (32'(ptr) + k) % n;
                if (valid[idx[2:0]]) begin
                    pick = {1'b1, idx[2:0]};
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/fdiv.sv
// Combinational single-precision divider y = x1 / x2.
// Zero exponent inputs are treated as zero, underflow flushes to signed zero,
// overflow and divide-by-zero saturate to infinity.
module fdiv (
    input  logic [31:0] x1,
    input  logic [31:0] x2,
    output logic [31:0] y
);

    logic               sign;
    logic [7:0]         ea;
    logic [7:0]         eb;
    logic [23:0]        ma;
    logic [23:0]        mb;
    logic [47:0]        num;
    logic [47:0]        den;
    logic [24:0]        q;
    logic [23:0]        norm;
    logic signed [9:0]  e;
    logic [30:0]        mag;

    // Mantissa quotient, normalisation, round-half-up and exponent handling
    always_comb begin
        sign = x1[31] ^ x2[31];
        ea   = x1[30:23];
        eb   = x2[30:23];
        ma   = {1'b1, x1[22:0]};
        mb   = {1'b1, x2[22:0]};
        num  = {ma, 24'b0};
        den  = {24'b0, mb};
        q    = 25'(num / den);
        // q lies in (2^23, 2^25); bit 24 set means ma >= mb
        norm = q[24] ? q[23:0] : {q[22:0], 1'b0};
        e    = $signed({2'b00, ea}) - $signed({2'b00, eb})
             + (q[24] ? 10'sd127 : 10'sd126);
        mag  = {e[7:0], norm[23:1]} + 31'(norm[0]);
        if (ea == 8'd0 || eb == 8'hFF) begin
            y = {sign, 31'b0};
        end else if (eb == 8'd0 || ea == 8'hFF) begin
            y = {sign, 8'hFF, 23'b0};
        end else if (e <= 10'sd0) begin
            y = {sign, 31'b0};
        end else if (e >= 10'sd255) begin
            y = {sign, 8'hFF, 23'b0};
        end else begin
            y = {sign, mag};
        end
    end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant plus binary index.
module rr_arbiter
    import fdiv_ctrl_pkg::*;
#(
    parameter  int unsigned N     = 2,
    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     valid,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    logic [7:0] valid_ext;
    logic [3:0] pick;

    // Search from ptr upward, wrapping, for the first valid requester
    always_comb begin
        valid_ext          = '0;
        valid_ext[N-1:0]   = valid;
        pick               = rr_pick(valid_ext, 3'(ptr), N);
        any                = pick[3];
        idx                = IDX_W'(pick[2:0]);
        grant              = '0;
        if (any) begin
            grant[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/fdiv_share_ctrl.sv
// Shares one combinational fdiv among NREQ requesters with round-robin
// arbitration, multicycle operand hold and a valid/ready result return.
module fdiv_share_ctrl
    import fdiv_ctrl_pkg::*;
#(
    parameter  int unsigned NREQ       = 2,
    parameter  int unsigned DIV_CYCLES = 4,
    parameter  int unsigned TAG_W      = 5,
    localparam int unsigned IDX_W      = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  flush,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*32-1:0]    req_x1,
    input  logic [NREQ*32-1:0]    req_x2,
    input  logic [NREQ*TAG_W-1:0] req_tag,
    output logic [NREQ-1:0]       resp_valid,
    input  logic [NREQ-1:0]       resp_ready,
    output logic [31:0]           resp_y,
    output logic [TAG_W-1:0]      resp_tag,
    output logic                  busy
);

    fdiv_state_t       state;
    logic [3:0]        cnt;
    logic [IDX_W-1:0]  rr_ptr;
    logic [IDX_W-1:0]  op_idx;
    logic [FP_W-1:0]   op_x1;
    logic [FP_W-1:0]   op_x2;
    logic [TAG_W-1:0]  op_tag;
    logic [FP_W-1:0]   res_y;

    logic [NREQ-1:0]   arb_grant;
    logic [IDX_W-1:0]  arb_idx;
    logic              arb_any;
    logic [FP_W-1:0]   sel_x1;
    logic [FP_W-1:0]   sel_x2;
    logic [TAG_W-1:0]  sel_tag;
    logic [NREQ-1:0]   idx_onehot;
    logic [FP_W-1:0]   fdiv_y;

    rr_arbiter #(.N(NREQ)) u_arb (
        .valid (req_valid),
        .ptr   (rr_ptr),
        .grant (arb_grant),
        .idx   (arb_idx),
        .any   (arb_any)
    );

    // Operands reach fdiv only from the op registers, so the path is multicycle
    fdiv u_fdiv (
        .x1 (op_x1),
        .x2 (op_x2),
        .y  (fdiv_y)
    );

    // Select the granted requester's operands and tag
    always_comb begin
        sel_x1  = req_x1[FP_W*arb_idx +: FP_W];
        sel_x2  = req_x2[FP_W*arb_idx +: FP_W];
        sel_tag = req_tag[TAG_W*arb_idx +: TAG_W];
    end

    // One-hot form of the latched winner for the response valid
    always_comb begin
        idx_onehot         = '0;
        idx_onehot[op_idx] = 1'b1;
    end

    // Accept only in IDLE, never during flush, and nothing while in reset
    always_comb begin
        req_ready = '0;
        if (rstn && !flush && state == IDLE) begin
            req_ready = arb_grant;
        end
    end

    assign busy     = (state != IDLE);
    assign resp_y   = res_y;
    assign resp_tag = op_tag;

    // Controller FSM: accept, hold operands DIV_CYCLES cycles, present result
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            cnt        <= '0;
            rr_ptr     <= '0;
            op_idx     <= '0;
            op_x1      <= '0;
            op_x2      <= '0;
            op_tag     <= '0;
            res_y      <= '0;
            resp_valid <= '0;
        end else if (flush) begin
            state      <= IDLE;
            cnt        <= '0;
            resp_valid <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (arb_any) begin
                        op_x1  <= sel_x1;
                        op_x2  <= sel_x2;
                        op_tag <= sel_tag;
                        op_idx <= arb_idx;
                        cnt    <= 4'(DIV_CYCLES - 1);
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    if (cnt == 4'd0) begin
                        res_y      <= fdiv_y;
                        resp_valid <= idx_onehot;
                        state      <= DONE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                DONE: begin
                    if (resp_ready[op_idx]) begin
                        resp_valid <= '0;
                        rr_ptr     <= (op_idx == IDX_W'(NREQ - 1)) ? '0 : op_idx + 1'b1;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fdiv_share_ctrl.sv
// Directed self-checking bench for fdiv_share_ctrl (NREQ=2, DIV_CYCLES=4, TAG_W=5).
module tb_fdiv_share_ctrl;

    logic        clk;
    logic        rstn;
    logic        flush;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [63:0] req_x1;
    logic [63:0] req_x2;
    logic [9:0]  req_tag;
    logic [1:0]  resp_valid;
    logic [1:0]  resp_ready;
    logic [31:0] resp_y;
    logic [4:0]  resp_tag;
    logic        busy;

    int total;
    int fails;
    int cyc;

    fdiv_share_ctrl #(
        .NREQ       (2),
        .DIV_CYCLES (4),
        .TAG_W      (5)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .flush      (flush),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_x1     (req_x1),
        .req_x2     (req_x2),
        .req_tag    (req_tag),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_y     (resp_y),
        .resp_tag   (resp_tag),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_resp(output int n);
        n = 0;
        while (resp_valid == 2'b00 && n < 20) begin
            tick();
            n++;
        end
    endtask

    task automatic set_req(input int i, input logic [31:0] x1, input logic [31:0] x2,
                           input logic [4:0] tag);
        req_x1[32*i +: 32] = x1;
        req_x2[32*i +: 32] = x2;
        req_tag[5*i +: 5]  = tag;
    endtask

    initial begin
        int          n;
        int          acc_cyc;
        int          prev_acc;
        int          d;
        logic        flag;
        logic [31:0] y0;
        logic [31:0] yv;
        logic [31:0] exp_y [2];
        logic [4:0]  exp_tag [2];
        logic [1:0]  exp_g;

        total = 0; fails = 0; cyc = 0;
        rstn = 1'b0; flush = 1'b0;
        req_valid = '0; resp_ready = '0;
        req_x1 = '0; req_x2 = '0; req_tag = '0;

        // Reset state, including req_ready held low while reset is active
        tick();
        tick();
        req_valid = 2'b11;
        #1;
        check("rst_req_ready", 32'(req_ready), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_resp_valid", 32'(resp_valid), 32'h0);
        check("rst_resp_y", resp_y, 32'h0);
        check("rst_resp_tag", 32'(resp_tag), 32'h0);
        req_valid = 2'b00;
        tick();
        rstn = 1'b1;
        tick();

        // 1. Single op 6.0 / 2.0 on requester 0
        set_req(0, 32'h40C00000, 32'h40000000, 5'd3);
        req_valid = 2'b01;
        #1;
        check("t1_req_ready", 32'(req_ready), 32'h1);
        acc_cyc = cyc;
        tick();
        req_valid = 2'b00;
        check("t1_busy_exec", 32'(busy), 32'h1);
        check("t1_req_ready_exec", 32'(req_ready), 32'h0);
        wait_resp(n);
        check("t1_latency", 32'(cyc - acc_cyc), 32'd5);
        check("t1_resp_valid", 32'(resp_valid), 32'h1);
        check("t1_resp_y", resp_y, 32'h40400000);
        check("t1_resp_tag", 32'(resp_tag), 32'd3);
        resp_ready = 2'b01;
        tick();
        resp_ready = 2'b00;
        check("t1_busy_after", 32'(busy), 32'h0);
        check("t1_resp_valid_after", 32'(resp_valid), 32'h0);

        // 2. Both requesters valid from reset: grants alternate 0,1,0,1
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        set_req(0, 32'h40C00000, 32'h40000000, 5'd7);
        set_req(1, 32'h41000000, 32'h40000000, 5'd9);
        exp_y[0] = 32'h40400000; exp_tag[0] = 5'd7;
        exp_y[1] = 32'h40800000; exp_tag[1] = 5'd9;
        req_valid  = 2'b11;
        resp_ready = 2'b11;
        prev_acc   = 0;
        for (int k = 0; k < 4; k++) begin
            exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
            #1;
            check($sformatf("t2_grant%0d", k), 32'(req_ready), 32'(exp_g));
            acc_cyc = cyc;
            if (k > 0) begin
                check($sformatf("t2_spacing%0d", k), 32'(acc_cyc - prev_acc), 32'd6);
            end
            prev_acc = acc_cyc;
            tick();
            wait_resp(n);
            check($sformatf("t2_latency%0d", k), 32'(cyc - acc_cyc), 32'd5);
            check($sformatf("t2_resp_valid%0d", k), 32'(resp_valid), 32'(exp_g));
            check($sformatf("t2_resp_y%0d", k), resp_y, exp_y[k % 2]);
            check($sformatf("t2_resp_tag%0d", k), 32'(resp_tag), 32'(exp_tag[k % 2]));
            tick();
        end
        req_valid  = 2'b00;
        resp_ready = 2'b00;
        tick();

        // 3. 1.0 / 3.0 within 2 ulp, result held while not consumed
        set_req(0, 32'h3F800000, 32'h40400000, 5'd5);
        req_valid = 2'b01;
        tick();
        req_valid = 2'b00;
        wait_resp(n);
        check("t3_resp_valid", 32'(resp_valid), 32'h1);
        d = int'(resp_y) - int'(32'h3EAAAAAB);
        check("t3_ulp", 32'((d >= -2) && (d <= 2)), 32'h1);
        check("t3_resp_tag", 32'(resp_tag), 32'd5);
        y0   = resp_y;
        flag = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (resp_y !== y0 || resp_tag !== 5'd5 || resp_valid !== 2'b01) flag = 1'b0;
        end
        check("t3_stable", 32'(flag), 32'h1);
        resp_ready = 2'b01;
        tick();
        resp_ready = 2'b00;

        // 4. Underflow flushes exponent; resp_ready on the other index ignored
        set_req(0, 32'h00800000, 32'h7F000000, 5'd2);
        req_valid = 2'b01;
        #1;
        check("t4_req_ready", 32'(req_ready), 32'h1);
        tick();
        req_valid = 2'b00;
        wait_resp(n);
        yv = resp_y;
        check("t4_exp_zero", 32'(yv[30:23]), 32'h0);
        resp_ready = 2'b10;
        for (int k = 0; k < 3; k++) tick();
        check("t4_ignored_valid", 32'(resp_valid), 32'h1);
        check("t4_ignored_busy", 32'(busy), 32'h1);
        resp_ready = 2'b01;
        tick();
        resp_ready = 2'b00;
        check("t4_done_busy", 32'(busy), 32'h0);

        // 5. Flush in EXEC at cnt==2, then flush in IDLE blocks accept
        set_req(1, 32'h41000000, 32'h40000000, 5'd9);
        req_valid = 2'b11;
        #1;
        check("t5_grant_ptr1", 32'(req_ready), 32'h2);
        tick();
        req_valid = 2'b00;
        tick();
        flush = 1'b1;
        #1;
        check("t5_flush_busy_before", 32'(busy), 32'h1);
        tick();
        flush = 1'b0;
        check("t5_flush_busy", 32'(busy), 32'h0);
        flag = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (resp_valid !== 2'b00) flag = 1'b0;
        end
        check("t5_no_resp", 32'(flag), 32'h1);
        req_valid = 2'b11;
        flush = 1'b1;
        #1;
        check("t5_flush_no_ready", 32'(req_ready), 32'h0);
        tick();
        check("t5_flush_no_accept", 32'(busy), 32'h0);
        flush = 1'b0;
        #1;
        check("t5_grant_after_flush", 32'(req_ready), 32'h2);
        tick();
        req_valid = 2'b00;
        wait_resp(n);
        check("t5_resp_valid", 32'(resp_valid), 32'h2);
        check("t5_resp_y", resp_y, 32'h40800000);
        resp_ready = 2'b10;
        tick();
        resp_ready = 2'b00;

        // 6. Reset while in DONE clears outputs and the round-robin pointer
        set_req(0, 32'h40C00000, 32'h40000000, 5'd3);
        req_valid  = 2'b01;
        resp_ready = 2'b01;
        tick();
        req_valid = 2'b00;
        wait_resp(n);
        tick();
        resp_ready = 2'b00;
        req_valid  = 2'b01;
        #1;
        check("t6_req_ready", 32'(req_ready), 32'h1);
        tick();
        req_valid = 2'b00;
        wait_resp(n);
        check("t6_in_done", 32'(resp_valid), 32'h1);
        rstn = 1'b0;
        req_valid = 2'b11;
        #1;
        check("t6_rst_resp_valid", 32'(resp_valid), 32'h0);
        check("t6_rst_busy", 32'(busy), 32'h0);
        check("t6_rst_resp_y", resp_y, 32'h0);
        check("t6_rst_resp_tag", 32'(resp_tag), 32'h0);
        check("t6_rst_req_ready", 32'(req_ready), 32'h0);
        tick();
        rstn = 1'b1;
        req_valid = 2'b00;
        flag = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (resp_valid !== 2'b00 || busy !== 1'b0) flag = 1'b0;
        end
        check("t6_idle_no_resp", 32'(flag), 32'h1);
        req_valid = 2'b11;
        #1;
        check("t6_ptr_reset", 32'(req_ready), 32'h1);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
